// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: display reads take every requested slot,
// queued host writes retire on idle cycles, optionally only in vblank.
module vram_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 1024
) (
  input  logic                            VGA_CLK,
  input  logic                            RST,
  input  logic                            DISP_REQ,
  input  logic [ADDR_W-1:0]               DISP_ADDR,
  output logic [DATA_W-1:0]               DISP_DATA,
  output logic                            DISP_VALID,
  input  logic                            WR_VALID,
  output logic                            WR_READY,
  input  logic [ADDR_W-1:0]               WR_ADDR,
  input  logic [DATA_W-1:0]               WR_DATA,
  input  logic                            BLANK_ONLY,
  input  logic                            IN_VBLANK,
  output logic [ADDR_W-1:0]               RAM_ADDR,
  output logic [DATA_W-1:0]               RAM_WDATA,
  output logic                            RAM_WE,
  input  logic [DATA_W-1:0]               RAM_RDATA,
  output logic                            WR_PENDING,
  output logic                            WR_STARVED,
  output logic [$clog2(FIFO_DEPTH):0]     FIFO_LEVEL
);

  localparam int PW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = PW - 1;

  logic [ADDR_W-1:0] f_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] f_data [FIFO_DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [PW-1:0]     wptr_n, rptr_n;
  logic              full, empty;
  logic              push, pop;
  logic [15:0]       stall, stall_n;
  logic [1:0]        vpipe;

  assign empty = (wptr == rptr);
  assign full  = (wptr[IW] != rptr[IW]) &&
                 (wptr[IW-1:0] == rptr[IW-1:0]);

  assign push = WR_VALID && !full;
  // Display always owns the slot; writes only fill idle cycles.
  assign pop  = !DISP_REQ && !empty &&
                (!BLANK_ONLY || IN_VBLANK);

  assign wptr_n = wptr + PW'(push);
  assign rptr_n = rptr + PW'(pop);

  assign stall_n = (empty || pop) ? 16'd0 :
                   (stall == 16'hFFFF) ? stall :
                   stall + 16'd1;

  assign WR_READY   = !full;
  assign FIFO_LEVEL = wptr - rptr;
  assign DISP_DATA  = RAM_RDATA;
  assign DISP_VALID = vpipe[1];

  always_ff @(posedge VGA_CLK) begin
    if (push) begin
      f_addr[wptr[IW-1:0]] <= WR_ADDR;
      f_data[wptr[IW-1:0]] <= WR_DATA;
    end
  end

  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      wptr       <= '0;
      rptr       <= '0;
      stall      <= '0;
      WR_STARVED <= 1'b0;
      WR_PENDING <= 1'b0;
      vpipe      <= '0;
      RAM_ADDR   <= '0;
      RAM_WDATA  <= '0;
      RAM_WE     <= 1'b0;
    end else begin
      wptr       <= wptr_n;
      rptr       <= rptr_n;
      stall      <= stall_n;
      WR_STARVED <= (stall_n >= 16'(STARVE_LIMIT));
      WR_PENDING <= (wptr_n != rptr_n);
      vpipe      <= {vpipe[0], DISP_REQ};
      if (DISP_REQ) begin
        RAM_ADDR <= DISP_ADDR;
        RAM_WE   <= 1'b0;
      end else if (pop) begin
        RAM_ADDR  <= f_addr[rptr[IW-1:0]];
        RAM_WDATA <= f_data[rptr[IW-1:0]];
        RAM_WE    <= 1'b1;
      end else begin
        RAM_WE <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: scoreboard queues filled by stimulus,
// drained by a negedge monitor watching RAM_WE and DISP_VALID.
module tb_vram_arbiter;

  localparam int AW = 19;
  localparam int DW = 8;

  logic          VGA_CLK = 1'b0;
  logic          RST = 1'b1;
  logic          DISP_REQ = 1'b0;
  logic [AW-1:0] DISP_ADDR = '0;
  logic [DW-1:0] DISP_DATA;
  logic          DISP_VALID;
  logic          WR_VALID = 1'b0;
  logic          WR_READY;
  logic [AW-1:0] WR_ADDR = '0;
  logic [DW-1:0] WR_DATA = '0;
  logic          BLANK_ONLY = 1'b0;
  logic          IN_VBLANK = 1'b0;
  logic [AW-1:0] RAM_ADDR;
  logic [DW-1:0] RAM_WDATA;
  logic          RAM_WE;
  logic [DW-1:0] RAM_RDATA = '0;
  logic          WR_PENDING;
  logic          WR_STARVED;
  logic [2:0]    FIFO_LEVEL;

  logic [DW-1:0] mem [256];

  int n_chk  = 0;
  int n_fail = 0;

  logic [AW+DW-1:0] wq[$];
  logic [DW-1:0]    dq[$];

  vram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW),
    .FIFO_DEPTH(4), .STARVE_LIMIT(8)
  ) dut (
    .VGA_CLK(VGA_CLK), .RST(RST),
    .DISP_REQ(DISP_REQ), .DISP_ADDR(DISP_ADDR),
    .DISP_DATA(DISP_DATA), .DISP_VALID(DISP_VALID),
    .WR_VALID(WR_VALID), .WR_READY(WR_READY),
    .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .BLANK_ONLY(BLANK_ONLY), .IN_VBLANK(IN_VBLANK),
    .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA),
    .RAM_WE(RAM_WE), .RAM_RDATA(RAM_RDATA),
    .WR_PENDING(WR_PENDING), .WR_STARVED(WR_STARVED),
    .FIFO_LEVEL(FIFO_LEVEL)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  // Synchronous RAM; word 0x10 is a fixed preloaded pixel 0xA5.
  always @(posedge VGA_CLK) begin
    if (RAM_WE) mem[RAM_ADDR[7:0]] <= RAM_WDATA;
    RAM_RDATA <= (RAM_ADDR[7:0] == 8'h10) ? 8'hA5
                                          : mem[RAM_ADDR[7:0]];
  end

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  always @(negedge VGA_CLK) begin
    if (!RST) begin
      if (RAM_WE) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", 32'(RAM_ADDR), 32'hFFFFFFFF);
        end else begin
          logic [AW+DW-1:0] e;
          e = wq.pop_front();
          chk("wr_addr", 32'(RAM_ADDR), 32'(e[AW+DW-1:DW]));
          chk("wr_data", 32'(RAM_WDATA), 32'(e[DW-1:0]));
        end
      end
      if (DISP_VALID) begin
        if (dq.size() == 0) begin
          chk("unexpected_valid", 32'(DISP_DATA), 32'hFFFFFFFF);
        end else begin
          logic [DW-1:0] d;
          d = dq.pop_front();
          chk("disp_data", 32'(DISP_DATA), 32'(d));
        end
      end
    end
  end

  task automatic tick();
    if (DISP_REQ && !RST) dq.push_back(8'hA5);
    @(posedge VGA_CLK);
    #1;
  endtask

  task automatic push_write(logic [AW-1:0] a, logic [DW-1:0] d);
    WR_VALID = 1'b1;
    WR_ADDR  = a;
    WR_DATA  = d;
    for (int i = 0; i < 20; i++) begin
      if (WR_READY) begin
        wq.push_back({a, d});
        tick();
        WR_VALID = 1'b0;
        return;
      end
      tick();
    end
    chk("push_timeout", 32'd0, 32'd1);
    WR_VALID = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    DISP_ADDR = 19'h00010;
    repeat (2) @(posedge VGA_CLK);
    #1;
    chk("rst_ram_we", 32'(RAM_WE), 32'd0);
    chk("rst_ram_addr", 32'(RAM_ADDR), 32'd0);
    chk("rst_ram_wdata", 32'(RAM_WDATA), 32'd0);
    chk("rst_disp_valid", 32'(DISP_VALID), 32'd0);
    chk("rst_level", 32'(FIFO_LEVEL), 32'd0);
    chk("rst_pending", 32'(WR_PENDING), 32'd0);
    chk("rst_starved", 32'(WR_STARVED), 32'd0);
    RST = 1'b0;
    #1;
    chk("rst_ready", 32'(WR_READY), 32'd1);
    tick();

    // single display read
    DISP_REQ = 1'b1;
    tick();
    chk("rd_ram_addr", 32'(RAM_ADDR), 32'h10);
    chk("rd_ram_we", 32'(RAM_WE), 32'd0);
    chk("rd_valid_t1", 32'(DISP_VALID), 32'd0);
    DISP_REQ = 1'b0;
    tick();
    chk("rd_valid_t2", 32'(DISP_VALID), 32'd1);
    chk("rd_data_t2", 32'(DISP_DATA), 32'hA5);
    tick();
    chk("rd_valid_t3", 32'(DISP_VALID), 32'd0);

    // three back-to-back writes
    push_write(19'd1, 8'h11);
    chk("w3_we_t1", 32'(RAM_WE), 32'd0);
    push_write(19'd2, 8'h22);
    chk("w3_we_t2", 32'(RAM_WE), 32'd1);
    chk("w3_addr_t2", 32'(RAM_ADDR), 32'd1);
    push_write(19'd3, 8'h33);
    chk("w3_addr_t3", 32'(RAM_ADDR), 32'd2);
    tick();
    chk("w3_we_t4", 32'(RAM_WE), 32'd1);
    chk("w3_addr_t4", 32'(RAM_ADDR), 32'd3);
    tick();
    chk("w3_we_t5", 32'(RAM_WE), 32'd0);
    chk("w3_level", 32'(FIFO_LEVEL), 32'd0);

    // fill FIFO behind continuous display reads
    DISP_REQ = 1'b1;
    for (int i = 0; i < 4; i++)
      push_write(19'h20 + 19'(i), 8'h40 + 8'(i));
    chk("full_ready", 32'(WR_READY), 32'd0);
    chk("full_level", 32'(FIFO_LEVEL), 32'd4);
    WR_VALID = 1'b1;
    WR_ADDR  = 19'h24;
    WR_DATA  = 8'h44;
    tick();
    tick();
    chk("full_no_we", 32'(RAM_WE), 32'd0);
    chk("full_held", 32'(FIFO_LEVEL), 32'd4);
    chk("full_ready2", 32'(WR_READY), 32'd0);
    DISP_REQ = 1'b0;
    push_write(19'h24, 8'h44);
    chk("drain_we", 32'(RAM_WE), 32'd1);
    chk("drain_addr", 32'(RAM_ADDR), 32'h21);
    repeat (3) tick();
    chk("drain_last", 32'(RAM_ADDR), 32'h24);
    chk("drain_level", 32'(FIFO_LEVEL), 32'd0);
    tick();
    chk("drain_idle", 32'(RAM_WE), 32'd0);

    // blank-only gating
    BLANK_ONLY = 1'b1;
    push_write(19'h30, 8'h55);
    push_write(19'h31, 8'h66);
    repeat (2) tick();
    chk("blank_no_we", 32'(RAM_WE), 32'd0);
    chk("blank_pending", 32'(WR_PENDING), 32'd1);
    chk("blank_level", 32'(FIFO_LEVEL), 32'd2);
    IN_VBLANK = 1'b1;
    tick();
    chk("vb_addr1", 32'(RAM_ADDR), 32'h30);
    chk("vb_we1", 32'(RAM_WE), 32'd1);
    tick();
    chk("vb_addr2", 32'(RAM_ADDR), 32'h31);
    chk("vb_pending", 32'(WR_PENDING), 32'd0);
    tick();
    chk("vb_idle", 32'(RAM_WE), 32'd0);
    IN_VBLANK  = 1'b0;
    BLANK_ONLY = 1'b0;

    // starvation flag
    DISP_REQ = 1'b1;
    push_write(19'h40, 8'h77);
    repeat (7) tick();
    chk("starve_7", 32'(WR_STARVED), 32'd0);
    tick();
    chk("starve_8", 32'(WR_STARVED), 32'd1);
    DISP_REQ = 1'b0;
    tick();
    chk("starve_clr", 32'(WR_STARVED), 32'd0);
    chk("starve_we", 32'(RAM_WE), 32'd1);
    chk("starve_addr", 32'(RAM_ADDR), 32'h40);
    repeat (3) tick();

    // reset mid-operation
    BLANK_ONLY = 1'b1;
    push_write(19'h50, 8'h01);
    push_write(19'h51, 8'h02);
    push_write(19'h52, 8'h03);
    DISP_REQ = 1'b1;
    tick();
    DISP_REQ   = 1'b0;
    BLANK_ONLY = 1'b0;
    tick();
    chk("pre_rst_we", 32'(RAM_WE), 32'd1);
    chk("pre_rst_level", 32'(FIFO_LEVEL), 32'd2);
    RST = 1'b1;
    #1;
    chk("mid_rst_we", 32'(RAM_WE), 32'd0);
    chk("mid_rst_valid", 32'(DISP_VALID), 32'd0);
    chk("mid_rst_level", 32'(FIFO_LEVEL), 32'd0);
    wq.delete();
    dq.delete();
    tick();
    RST = 1'b0;
    #1;
    chk("post_rst_level", 32'(FIFO_LEVEL), 32'd0);
    chk("post_rst_ready", 32'(WR_READY), 32'd1);
    chk("post_rst_pend", 32'(WR_PENDING), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_valid", 32'(DISP_VALID), 32'd0);
      chk("post_rst_we", 32'(RAM_WE), 32'd0);
    end

    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
